keypad_ndigit_display: RTL and testbench

- Parametrised successor to the fixed two-digit keypad display path: N-digit key-history display driver for the iCE40 keypad lab.
- Accepts one-cycle key events from the keypad scanner and shifts each key code into an N-digit history (newest key on digit 0).
- Time-multiplexes the history onto one shared seven-segment bus with a programmable refresh divider, a one-cycle anode dead-time, and optional blanking of unfilled digits.
- Sits between the keypad scanner/debouncer and the board segment/anode pins, clocked from the HSOSC clock.

---
 rtl/keypad_disp_pkg.sv | 24 ++
 rtl/hex7seg.sv | 16 +
 rtl/keypad_ndigit_display.sv | 106 ++++++++++
 tb/tb_keypad_ndigit_display.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/keypad_disp_pkg.sv
// Shared types, constants and helpers for the keypad N-digit display path.
// Segment patterns here are active-high, bit 0 = a ... bit 6 = g.
package keypad_disp_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b000_0000;

  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One-hot select of idx, limited to the n implemented anodes (max 8).
  function automatic logic [7:0] onehot_sel(input logic [2:0] idx, input int n);
    logic [7:0] sel;
    sel = '0;
    for (int i = 0; i < 8; i++) begin
      if ((i < n) && (idx == 3'(i))) sel[i] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to seven-segment decode with selectable polarity.
// Zero latency, no flow control.
module hex7seg
  import keypad_disp_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = (SEG_ACTIVE_LOW != 0) ? ~HEX_SEG[hex] : HEX_SEG[hex];
  end

endmodule

// File: rtl/keypad_ndigit_display.sv
// N-digit key-history display: shifts key codes into a history and scans it onto one
// shared segment bus; outputs registered, keys accepted every cycle (never stalls).
module keypad_ndigit_display
  import keypad_disp_pkg::*;
#(
  parameter int NDIG           = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_UNFILLED = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_valid,
  input  logic [3:0]                 key_code,
  input  logic                       clear,
  output logic [6:0]                 seg,
  output logic [NDIG-1:0]            an,
  output logic [$clog2(NDIG+1)-1:0]  fill
);

  localparam int IDXW  = $clog2(NDIG);
  localparam int CNTW  = $clog2(REFRESH_DIV);
  localparam int FILLW = $clog2(NDIG+1);

  localparam logic [NDIG-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam seg_t            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

  logic [CNTW-1:0]  cnt_q,  cnt_d;
  logic [IDXW-1:0]  idx_q,  idx_d;
  logic [FILLW-1:0] fill_q, fill_d;
  logic [3:0]       digits_q [NDIG];
  logic [3:0]       digits_d [NDIG];
  logic [NDIG-1:0]  an_q,   an_d;
  seg_t             seg_q,  seg_d;

  logic             tick;
  logic             blank;
  logic [3:0]       digit_cur;
  logic [NDIG-1:0]  an_sel;
  seg_t             seg_dec;

  assign digit_cur = digits_q[idx_q];

  hex7seg #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_hex7seg (
    .hex(digit_cur),
    .seg(seg_dec)
  );

  always_comb begin
    tick   = (cnt_q == CNTW'(REFRESH_DIV - 1));
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDXW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end

    // Clear has priority; a key arriving with it is dropped.
    digits_d = digits_q;
    fill_d   = fill_q;
    if (clear) begin
      for (int i = 0; i < NDIG; i++) digits_d[i] = '0;
      fill_d = '0;
    end else if (key_valid) begin
      for (int i = 1; i < NDIG; i++) digits_d[i] = digits_q[i-1];
      digits_d[0] = key_code;
      if (fill_q != FILLW'(NDIG)) fill_d = fill_q + 1'b1;
    end

    an_sel = NDIG'(onehot_sel(3'(idx_q), NDIG));
    blank  = (BLANK_UNFILLED != 0) && (FILLW'(idx_q) >= fill_q);

    // The tick cycle becomes a dead cycle so the old digit never ghosts onto the next anode.
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (!tick) begin
      an_d  = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
      seg_d = blank ? SEG_OFF : seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      fill_q <= '0;
      for (int i = 0; i < NDIG; i++) digits_q[i] <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      fill_q <= fill_d;
      for (int i = 0; i < NDIG; i++) digits_q[i] <= digits_d[i];
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign fill = fill_q;

endmodule

// File: tb/tb_keypad_ndigit_display.sv
// Directed bench for keypad_ndigit_display: NDIG=4, REFRESH_DIV=4, active-low outputs,
// one instance with blanking of unfilled digits and one without.
module tb_keypad_ndigit_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       clear;

  logic [6:0] seg0, seg1;
  logic [3:0] an0,  an1;
  logic [2:0] fill0, fill1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  keypad_ndigit_display #(
    .NDIG(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_UNFILLED(1)
  ) u_dut0 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .clear(clear),
    .seg(seg0), .an(an0), .fill(fill0)
  );

  keypad_ndigit_display #(
    .NDIG(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_UNFILLED(0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .clear(clear),
    .seg(seg1), .an(an1), .fill(fill1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait until the chosen instance selects the target anode pattern.
  task automatic wait_an(input bit which, input logic [3:0] target, input string tag);
    logic [3:0] a;
    for (int i = 0; i < 40; i++) begin
      a = which ? an1 : an0;
      if (a == target) break;
      step();
    end
    a = which ? an1 : an0;
    chk({tag, "_an"}, 32'(a), 32'(target));
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
  endtask

  logic [3:0] exp_an [17] = '{
    4'b1110, 4'b1110, 4'b1110, 4'b1111,
    4'b1101, 4'b1101, 4'b1101, 4'b1111,
    4'b1011, 4'b1011, 4'b1011, 4'b1111,
    4'b0111, 4'b0111, 4'b0111, 4'b1111,
    4'b1110
  };
  logic [2:0] exp_fill [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    clear     = 1'b0;

    repeat (3) step();
    chk("rst_an",   32'(an0),   32'(4'b1111));
    chk("rst_seg",  32'(seg0),  32'(7'b1111111));
    chk("rst_fill", 32'(fill0), 32'(3'd0));
    reset = 1'b1;

    // Full scan period with an empty history: every slot stays blank.
    for (int k = 0; k < 17; k++) begin
      step();
      chk($sformatf("scan_an%0d", k), 32'(an0), 32'(exp_an[k]));
      chk($sformatf("scan_seg%0d", k), 32'(seg0), 32'(7'b1111111));
    end

    press(4'h1);
    chk("k1_fill", 32'(fill0), 32'(3'd1));
    step();
    chk("k1_d0_an",  32'(an0),  32'(4'b1110));
    chk("k1_d0_seg", 32'(seg0), 32'(7'b1111001));
    wait_an(1'b0, 4'b1101, "k1_d1");
    chk("k1_d1_seg", 32'(seg0), 32'(7'b1111111));
    wait_an(1'b0, 4'b0111, "k1_d3");
    chk("k1_d3_seg", 32'(seg0), 32'(7'b1111111));

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_fill", 32'(fill0), 32'(3'd0));

    for (int k = 0; k < 5; k++) begin
      press(4'(k + 1));
      chk($sformatf("seq_fill%0d", k), 32'(fill0), 32'(exp_fill[k]));
    end
    wait_an(1'b0, 4'b0111, "seq_d3");
    chk("seq_d3_seg", 32'(seg0), 32'(7'b0100100));
    wait_an(1'b0, 4'b1110, "seq_d0");
    chk("seq_d0_seg", 32'(seg0), 32'(7'b0010010));
    wait_an(1'b0, 4'b1101, "seq_d1");
    chk("seq_d1_seg", 32'(seg0), 32'(7'b0011001));
    wait_an(1'b0, 4'b1011, "seq_d2");
    chk("seq_d2_seg", 32'(seg0), 32'(7'b0110000));

    // Clear and key in the same cycle: the key must be dropped.
    clear     = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'hF;
    step();
    clear     = 1'b0;
    key_valid = 1'b0;
    chk("clrkey_fill", 32'(fill0), 32'(3'd0));
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("clrkey_seg%0d", k), 32'(seg0), 32'(7'b1111111));
    end

    press(4'h7);
    press(4'h8);
    press(4'h9);
    chk("pre_rst_fill", 32'(fill1), 32'(3'd3));
    step();
    step();

    // Reset mid-slot while a key strobe is also present.
    reset     = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h9;
    step();
    chk("mrst_an0",   32'(an0),   32'(4'b1111));
    chk("mrst_seg0",  32'(seg0),  32'(7'b1111111));
    chk("mrst_fill0", 32'(fill0), 32'(3'd0));
    chk("mrst_an1",   32'(an1),   32'(4'b1111));
    chk("mrst_seg1",  32'(seg1),  32'(7'b1111111));
    chk("mrst_fill1", 32'(fill1), 32'(3'd0));

    reset = 1'b1;
    press(4'h6);
    chk("post_fill1", 32'(fill1), 32'(3'd1));
    chk("post_an1",   32'(an1),   32'(4'b1110));
    chk("post_seg0",  32'(seg0),  32'(7'b1111111));
    chk("post_seg1",  32'(seg1),  32'(7'b1000000));
    step();
    chk("post6_seg1", 32'(seg1),  32'(7'b0000010));
    chk("post6_seg0", 32'(seg0),  32'(7'b0000010));
    wait_an(1'b1, 4'b0111, "nob_d3");
    chk("nob_d3_seg1", 32'(seg1), 32'(7'b1000000));
    chk("nob_d3_seg0", 32'(seg0), 32'(7'b1111111));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
